// File: rtl/alu_16bit.sv
// alu_16bit: registered 16-bit ALU with 32 functions selected by FS.
//   FS[4]=0    : bitwise logic, FS[3:0] is the truth table indexed by {A[i],B[i]}
//   FS[4:3]=10 : arithmetic X + Y + c through one 17-bit adder
//   FS[4:3]=11 : single-bit shift left/right (FS[0] selects direction)
// Build option: define ALU16_SHR_CIN_EN to shift Cin into F[15] on shift right;
// otherwise shift right is logical (fill 0).
module alu_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        Cin,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [4:0]  FS,
  output logic [15:0] F,
  output logic        Cout,
  output logic        Z,
  output logic        N,
  output logic        V
);

  logic [15:0] f_d, f_q;
  logic        cout_d, cout_q;
  logic        z_d, z_q;
  logic        n_d, n_q;
  logic        v_d, v_q;

  logic [3:0]  lut;
  logic [15:0] add_x, add_y;
  logic        add_c;
  logic [16:0] add_sum;
  logic        shr_fill;

`ifdef ALU16_SHR_CIN_EN
  assign shr_fill = Cin;
`else
  assign shr_fill = 1'b0;
`endif

  assign lut = FS[3:0];

  // Decode FS and compute the next result, carry and overflow
  always_comb begin
    f_d     = '0;
    cout_d  = 1'b0;
    v_d     = 1'b0;
    add_x   = A;
    add_y   = '0;
    add_c   = Cin;
    add_sum = '0;

    if (!FS[4]) begin
      for (int i = 0; i < 16; i++) begin
        f_d[i] = lut[{A[i], B[i]}];
      end
    end else if (!FS[3]) begin
      add_x = FS[0] ? ~A : A;
      unique case (FS[2:1])
        2'b00:   add_y = 16'h0000;
        2'b01:   add_y = 16'h0001;
        2'b10:   add_y = B;
        default: add_y = ~B;
      endcase
      // Negate (10001) forces the +1 regardless of Cin
      add_c   = (FS[2:0] == 3'b001) ? 1'b1 : Cin;
      add_sum = {1'b0, add_x} + {1'b0, add_y} + {16'h0000, add_c};
      f_d     = add_sum[15:0];
      cout_d  = add_sum[16];
      v_d     = (add_x[15] == add_y[15]) && (add_sum[15] != add_x[15]);
    end else begin
      if (!FS[0]) begin
        f_d    = {A[14:0], Cin};
        cout_d = A[15];
      end else begin
        f_d    = {shr_fill, A[15:1]};
        cout_d = A[0];
      end
    end
  end

  // Status flags follow the value being captured
  always_comb begin
    z_d = (f_d == 16'h0000);
    n_d = f_d[15];
  end

  // Output registers: async clear, capture only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= '0;
      cout_q <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
    end else if (en) begin
      f_q    <= f_d;
      cout_q <= cout_d;
      z_q    <= z_d;
      n_q    <= n_d;
      v_q    <= v_d;
    end
  end

  assign F    = f_q;
  assign Cout = cout_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign V    = v_q;

endmodule

// File: tb/tb_alu_16bit.sv
// Directed-vector bench for alu_16bit with hand-computed expectations.
module tb_alu_16bit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic [4:0]  fs;
  logic [15:0] f;
  logic        cout;
  logic        z;
  logic        n;
  logic        v;

  int n_cmp;
  int n_err;

  logic [15:0] exp_f [32];
  logic [31:0] exp_cout;

  alu_16bit u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .Cin  (cin),
    .A    (a),
    .B    (b),
    .FS   (fs),
    .F    (f),
    .Cout (cout),
    .Z    (z),
    .N    (n),
    .V    (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one operation between edges, then sample just after the capturing edge
  task automatic step(input logic [4:0] s, input logic [15:0] opa, input logic [15:0] opb,
                      input logic c);
    @(negedge clk);
    fs  = s;
    a   = opa;
    b   = opb;
    cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] ef, input logic ec,
                           input logic ez, input logic en_flag, input logic ev);
    check_eq({tag, ".F"}, f, ef);
    check_eq({tag, ".Cout"}, {15'd0, cout}, {15'd0, ec});
    check_eq({tag, ".Z"}, {15'd0, z}, {15'd0, ez});
    check_eq({tag, ".N"}, {15'd0, n}, {15'd0, en_flag});
    check_eq({tag, ".V"}, {15'd0, v}, {15'd0, ev});
  endtask

  initial begin
    logic [15:0] shr_exp;
    n_cmp = 0;
    n_err = 0;

    // A=A5C3, B=0FF0, Cin=1
    exp_f[0]  = 16'h0000; exp_f[1]  = 16'h500C; exp_f[2]  = 16'h0A30; exp_f[3]  = 16'h5A3C;
    exp_f[4]  = 16'hA003; exp_f[5]  = 16'hF00F; exp_f[6]  = 16'hAA33; exp_f[7]  = 16'hFA3F;
    exp_f[8]  = 16'h05C0; exp_f[9]  = 16'h55CC; exp_f[10] = 16'h0FF0; exp_f[11] = 16'h5FFC;
    exp_f[12] = 16'hA5C3; exp_f[13] = 16'hF5CF; exp_f[14] = 16'hAFF3; exp_f[15] = 16'hFFFF;
    exp_f[16] = 16'hA5C4; exp_f[17] = 16'h5A3D; exp_f[18] = 16'hA5C5; exp_f[19] = 16'h5A3E;
    exp_f[20] = 16'hB5B4; exp_f[21] = 16'h6A2D; exp_f[22] = 16'h95D3; exp_f[23] = 16'h4A4C;
`ifdef ALU16_SHR_CIN_EN
    shr_exp = 16'hD2E1;
`else
    shr_exp = 16'h52E1;
`endif
    for (int i = 24; i < 32; i += 2) begin
      exp_f[i]     = 16'h4B87;
      exp_f[i + 1] = shr_exp;
    end
    exp_cout = 32'hFFC0_0000;

    // Reset with no clock edge yet
    rst_n = 1'b0;
    en    = 1'b0;
    cin   = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    fs    = 5'b0;
    #2;
    check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    step(5'b01000, 16'h1234, 16'h00FF, 1'b0);
    check_all("first_and", 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full function sweep
    for (int i = 0; i < 32; i++) begin
      step(i[4:0], 16'hA5C3, 16'h0FF0, 1'b1);
      check_eq($sformatf("sweep%0d.F", i), f, exp_f[i]);
      check_eq($sformatf("sweep%0d.Cout", i), {15'd0, cout}, {15'd0, exp_cout[i]});
      check_eq($sformatf("sweep%0d.Z", i), {15'd0, z}, {15'd0, exp_f[i] == 16'h0000});
      check_eq($sformatf("sweep%0d.N", i), {15'd0, n}, {15'd0, exp_f[i][15]});
    end

    // Carry and overflow
    step(5'b10100, 16'hFFFF, 16'h0001, 1'b0);
    check_all("add_carry", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'b10100, 16'h7FFF, 16'h0001, 1'b0);
    check_all("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Subtract and negate
    step(5'b10110, 16'h0005, 16'h0003, 1'b1);
    check_all("sub", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'b10001, 16'h0000, 16'h1234, 1'b0);
    check_all("neg0", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'b10001, 16'h0001, 16'h1234, 1'b0);
    check_all("neg1", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

    // Shifts
    step(5'b11000, 16'h8001, 16'h0000, 1'b1);
    check_all("shl", 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'b11111, 16'h8001, 16'h0000, 1'b1);
`ifdef ALU16_SHR_CIN_EN
    check_all("shr", 16'hC000, 1'b1, 1'b0, 1'b1, 1'b0);
`else
    check_all("shr", 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Hold with en low while inputs change
    step(5'b01000, 16'hA5C3, 16'h0FF0, 1'b0);
    check_eq("hold_pre.F", f, 16'h05C0);
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fs  = 5'b10100;
      a   = 16'hFFFF;
      b   = 16'h0001 + k[15:0];
      cin = 1'b1;
      @(posedge clk);
      #1;
      check_all($sformatf("hold%0d", k), 16'h05C0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Mid-stream reset clears immediately and discards the pending result
    en  = 1'b1;
    fs  = 5'b01111;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("rst_hold.F", f, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
